debug_run_ctrl: RTL and testbench

//  Run/halt sequencer for external debug. Drives core_running, core_halted and dbg_ret into the pipeline

---
 rtl/dbg_pkg.sv | 33 +++
 rtl/debug_run_ctrl_if.sv | 34 +++
 rtl/debug_run_ctrl.sv | 111 +++++++++++
 tb/tb_debug_run_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types for the debug run/halt sequencer.
//   dbg_state_e      : sequencer state encoding
//   DBG_CAUSE_*      : dcsr.cause codes reported while halted
//   dbg_halt_cause() : cause of a halt event; a lower code means a higher priority
package dbg_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALT_WAIT,
        ST_HALT_ENTER,
        ST_HALTED,
        ST_RESUME,
        ST_STEP
    } dbg_state_e;

    localparam logic [2:0] DBG_CAUSE_NONE      = 3'd0;
    localparam logic [2:0] DBG_CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] DBG_CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] DBG_CAUSE_STEP      = 3'd4;
    localparam logic [2:0] DBG_CAUSE_RESETHALT = 3'd5;

    // The step cause is returned only when neither ebreak nor haltreq is present.
    function automatic logic [2:0] dbg_halt_cause(input logic ebreak, input logic haltreq);
        if (ebreak) begin
            return DBG_CAUSE_EBREAK;
        end else if (haltreq) begin
            return DBG_CAUSE_HALTREQ;
        end else begin
            return DBG_CAUSE_STEP;
        end
    endfunction

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Signal bundle between the debug module / pipeline and the run/halt sequencer.
//   master : debug module + pipeline side (drives requests and pipeline status)
//   slave  : sequencer side (drives run/halt qualifiers, status and CSR strobes)
interface debug_run_ctrl_if;

    logic       haltreq;
    logic       resumereq;
    logic       step_en;
    logic       ebreak_dbg;
    logic       instr_retired;
    logic       trap;
    logic       stall_pipl;
    logic       div_busy;

    logic       core_running;
    logic       core_halted;
    logic       dbg_ret;
    logic       halted;
    logic       resume_ack;
    logic       dpc_we;
    logic [2:0] dcsr_cause;
    logic       halt_forced;

    modport master (
        output haltreq, resumereq, step_en, ebreak_dbg, instr_retired, trap, stall_pipl, div_busy,
        input  core_running, core_halted, dbg_ret, halted, resume_ack, dpc_we, dcsr_cause, halt_forced
    );

    modport slave (
        input  haltreq, resumereq, step_en, ebreak_dbg, instr_retired, trap, stall_pipl, div_busy,
        output core_running, core_halted, dbg_ret, halted, resume_ack, dpc_we, dcsr_cause, halt_forced
    );

endinterface

// File: rtl/debug_run_ctrl.sv
// Run/halt sequencer for external debug. Freezes, flushes and restarts the pipeline
// at clean boundaries in response to haltreq, resumereq, debug ebreak and single-step.
// Ports:
//   clk      : core clock
//   reset_n  : synchronous active-low reset
//   bus      : debug_run_ctrl_if.slave (requests/pipeline status in; run/halt control, status,
//              dpc_we strobe, dcsr_cause and halt_forced out)
// Parameters:
//   MAX_WAIT   : cycles to wait for stall_pipl/div_busy to drop before forcing the halt (>=2)
//   RESET_HALT : 1 leaves reset HALTED with cause 5, 0 leaves reset in RUN
module debug_run_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned MAX_WAIT   = 16,
    parameter bit          RESET_HALT = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    debug_run_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    dbg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cause_q, cause_d;
    logic             forced_q, forced_d;

    logic             quiet;
    logic             run_evt;
    logic             step_evt;
    logic [2:0]       evt_cause;

    assign quiet     = ~bus.stall_pipl & ~bus.div_busy;
    assign run_evt   = bus.ebreak_dbg | bus.haltreq;
    assign step_evt  = run_evt | bus.instr_retired | bus.trap;
    assign evt_cause = dbg_halt_cause(bus.ebreak_dbg, bus.haltreq);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= RESET_HALT ? ST_HALTED : ST_RUN;
            cnt_q    <= '0;
            cause_q  <= RESET_HALT ? DBG_CAUSE_RESETHALT : DBG_CAUSE_NONE;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            forced_q <= forced_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        forced_d = forced_q;
        unique case (state_q)
            ST_RUN, ST_STEP: begin
                // The step term only counts while a single step is in flight.
                if (run_evt || (state_q == ST_STEP && step_evt)) begin
                    cause_d = evt_cause;
                    cnt_d   = '0;
                    state_d = quiet ? ST_HALT_ENTER : ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                if (run_evt && (evt_cause < cause_q)) begin
                    cause_d = evt_cause;
                end
                if (quiet) begin
                    state_d = ST_HALT_ENTER;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HALT_ENTER;
                    forced_d = 1'b1;
                end
            end
            ST_HALT_ENTER: begin
                state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (bus.resumereq) begin
                    state_d  = ST_RESUME;
                    forced_d = 1'b0;
                end
            end
            ST_RESUME: begin
                state_d = bus.step_en ? ST_STEP : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        bus.core_running = (state_q == ST_RUN) || (state_q == ST_HALT_WAIT) ||
                           (state_q == ST_RESUME) || (state_q == ST_STEP);
        bus.core_halted  = (state_q == ST_HALT_ENTER) || (state_q == ST_HALTED);
        bus.halted       = (state_q == ST_HALTED);
        bus.dpc_we       = (state_q == ST_HALT_ENTER);
        bus.dbg_ret      = (state_q == ST_RESUME);
        bus.resume_ack   = (state_q == ST_RESUME);
        bus.dcsr_cause   = cause_q;
        bus.halt_forced  = forced_q;
    end

endmodule

// File: tb/tb_debug_run_ctrl.sv
module tb_debug_run_ctrl;

    // in  = {reset_n, haltreq, resumereq, step_en, ebreak_dbg, instr_retired, trap, stall_pipl, div_busy}
    // exp = {core_running, core_halted, dbg_ret, halted, resume_ack, dpc_we, halt_forced, dcsr_cause[2:0]}
    typedef struct {
        string      name;
        logic [8:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_edges;
    vec_t vecs[$];

    always #5 clk = ~clk;

    debug_run_ctrl_if bus ();
    debug_run_ctrl_if bus2 ();

    debug_run_ctrl #(.MAX_WAIT(16), .RESET_HALT(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    debug_run_ctrl #(.MAX_WAIT(16), .RESET_HALT(1'b1)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    function automatic logic [9:0] out1();
        return {bus.core_running, bus.core_halted, bus.dbg_ret, bus.halted, bus.resume_ack,
                bus.dpc_we, bus.halt_forced, bus.dcsr_cause};
    endfunction

    function automatic logic [9:0] out2();
        return {bus2.core_running, bus2.core_halted, bus2.dbg_ret, bus2.halted, bus2.resume_ack,
                bus2.dpc_we, bus2.halt_forced, bus2.dcsr_cause};
    endfunction

    task automatic set_in(input logic [8:0] v);
        {reset_n, bus.haltreq, bus.resumereq, bus.step_en, bus.ebreak_dbg,
         bus.instr_retired, bus.trap, bus.stall_pipl, bus.div_busy} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [8:0] in, input logic [9:0] exp);
        vec_t v;
        v.name = name;
        v.in   = in;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        set_in(9'b0_0000_0000);
        {bus2.haltreq, bus2.resumereq, bus2.step_en, bus2.ebreak_dbg,
         bus2.instr_retired, bus2.trap, bus2.stall_pipl, bus2.div_busy} = '0;

        add("reset",            9'b0_0000_0000, 10'b1000000_000);
        add("idle_run",         9'b1_0000_0000, 10'b1000000_000);
        add("t1_halt_enter",    9'b1_1000_0000, 10'b0100010_011);
        add("t1_halted",        9'b1_1000_0000, 10'b0101000_011);
        add("t1_hold",          9'b1_0000_0000, 10'b0101000_011);
        add("t3_resume",        9'b1_0110_0000, 10'b1010100_011);
        add("t3_step",          9'b1_0010_0000, 10'b1000000_011);
        add("t3_step_idle",     9'b1_0010_0000, 10'b1000000_011);
        add("t3_retire",        9'b1_0010_1000, 10'b0100010_100);
        add("t3_halted",        9'b1_0010_0000, 10'b0101000_100);
        add("t4_resume",        9'b1_0110_0000, 10'b1010100_100);
        add("t4_step",          9'b1_0010_0000, 10'b1000000_100);
        add("t4_ebrk_retire",   9'b1_0011_1000, 10'b0100010_001);
        add("t4_halted",        9'b1_0000_0000, 10'b0101000_001);
        add("t5_resume_wins",   9'b1_1100_0000, 10'b1010100_001);
        add("t5_run",           9'b1_1000_0000, 10'b1000000_001);
        add("t5_rehalt",        9'b1_1000_0000, 10'b0100010_011);
        add("t5_halted",        9'b1_0000_0000, 10'b0101000_011);
        add("halted_ignores",   9'b1_1001_0000, 10'b0101000_011);
        add("resume_run",       9'b1_0100_0000, 10'b1010100_011);
        add("run",              9'b1_0000_0000, 10'b1000000_011);
        add("run_retire_nohlt", 9'b1_0000_1000, 10'b1000000_011);
        add("ebrk_trap",        9'b1_0001_0100, 10'b0100010_001);
        add("ebrk_trap_halted", 9'b1_0000_0000, 10'b0101000_001);
        add("resume_step",      9'b1_0110_0000, 10'b1010100_001);
        add("step2",            9'b1_0010_0000, 10'b1000000_001);
        add("step_trap",        9'b1_0010_0100, 10'b0100010_100);
        add("step_trap_halted", 9'b1_0000_0000, 10'b0101000_100);
        add("resume2",          9'b1_0100_0000, 10'b1010100_100);
        add("run2",             9'b1_0000_0000, 10'b1000000_100);

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].in);
            tick();
            check(vecs[i].name, 32'(out1()), 32'(vecs[i].exp));
            if (i == 0) begin
                check("rh_reset_state", 32'(out2()), 32'(10'b0101000_101));
            end
        end

        // Halt while stalled: stall drops after five stalled cycles.
        set_in(9'b1_1000_0010);
        tick();
        check("t2_wait_state", 32'(out1()), 32'(10'b1000000_011));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_wait_no_dpc", 32'(bus.dpc_we), 32'd0);
        end
        set_in(9'b1_1000_0000);
        tick();
        check("t2_enter_unforced", 32'(out1()), 32'(10'b0100010_011));
        set_in(9'b1_0000_0000);
        tick();
        set_in(9'b1_0100_0000);
        tick();
        set_in(9'b1_0000_0000);
        tick();
        check("t2_back_in_run", 32'(out1()), 32'(10'b1000000_011));

        // Stall never drops: halt is forced once the wait budget expires.
        set_in(9'b1_1000_0010);
        n_edges = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.dpc_we) begin
                n_edges = i;
                break;
            end
        end
        check("t2_forced_edges", 32'(n_edges), 32'd17);
        check("t2_forced_flag", 32'(bus.halt_forced), 32'd1);
        tick();
        check("t2_forced_halted", 32'(out1()), 32'(10'b0101001_011));
        set_in(9'b1_0100_0000);
        tick();
        check("t2_resume_clears", 32'(out1()), 32'(10'b1010100_011));
        set_in(9'b1_0000_0000);
        tick();

        // Cause upgrade while waiting on the divider.
        set_in(9'b1_1000_0001);
        tick();
        check("wait_cause_hreq", 32'(out1()), 32'(10'b1000000_011));
        set_in(9'b1_0001_0001);
        tick();
        check("wait_cause_ebrk", 32'(out1()), 32'(10'b1000000_001));
        set_in(9'b1_1000_0001);
        tick();
        check("wait_cause_keep", 32'(out1()), 32'(10'b1000000_001));
        set_in(9'b1_0000_0000);
        tick();
        check("wait_cause_enter", 32'(out1()), 32'(10'b0100010_001));
        tick();
        set_in(9'b1_0100_0000);
        tick();
        set_in(9'b1_0000_0000);
        tick();

        // Reset in the middle of HALT_WAIT.
        set_in(9'b1_1000_0010);
        tick();
        check("t6_in_wait", 32'(out1()), 32'(10'b1000000_011));
        set_in(9'b0_1000_0010);
        tick();
        check("t6_reset_run", 32'(out1()), 32'(10'b1000000_000));
        check("t6_reset_halt", 32'(out2()), 32'(10'b0101000_101));
        set_in(9'b1_0000_0000);
        tick();
        check("t6_after_reset", 32'(out1()), 32'(10'b1000000_000));
        bus2.resumereq = 1'b1;
        tick();
        check("rh_resume", 32'(out2()), 32'(10'b1010100_101));
        bus2.resumereq = 1'b0;
        tick();
        check("rh_run", 32'(out2()), 32'(10'b1000000_101));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
